// File: rtl/canvas_pkg.sv
// Shared canvas geometry, default widths and arbiter state type for the canvas port arbiter.
package canvas_pkg;

  localparam int unsigned CANVAS_W      = 32;
  localparam int unsigned CANVAS_H      = 32;
  localparam int unsigned CANVAS_PIXELS = CANVAS_W * CANVAS_H;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_CHAR_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRecog,
    StClear
  } arb_state_e;

endpackage

// File: rtl/canvas_port_arbiter_if.sv
// Bundle of pen, recognizer, RAM and character-handshake signals around the canvas port arbiter.
interface canvas_port_arbiter_if
  import canvas_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CHAR_W = DEF_CHAR_W
);

  logic              draw_we;
  logic [ADDR_W-1:0] draw_addr;
  logic              draw_data;
  logic              draw_done;
  logic              clear_req;
  logic              draw_stall;

  logic              rec_end_write;
  logic              rec_read_enable;
  logic [ADDR_W-1:0] rec_read_addr;
  logic              rec_read_data;
  logic              rec_ready_to_write;
  logic [CHAR_W-1:0] rec_write_data;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_wdata;
  logic              mem_rdata;

  logic              char_valid;
  logic [CHAR_W-1:0] char_data;
  logic              char_ready;

  logic              busy;
  logic              timeout_err;
  logic              char_overrun;

  modport master (
    input  draw_we, draw_addr, draw_data, draw_done, clear_req,
    input  rec_read_enable, rec_read_addr, rec_ready_to_write, rec_write_data,
    input  mem_rdata, char_ready,
    output draw_stall, rec_end_write, rec_read_data,
    output mem_addr, mem_we, mem_wdata,
    output char_valid, char_data, busy, timeout_err, char_overrun
  );

  modport slave (
    output draw_we, draw_addr, draw_data, draw_done, clear_req,
    output rec_read_enable, rec_read_addr, rec_ready_to_write, rec_write_data,
    output mem_rdata, char_ready,
    input  draw_stall, rec_end_write, rec_read_data,
    input  mem_addr, mem_we, mem_wdata,
    input  char_valid, char_data, busy, timeout_err, char_overrun
  );

endinterface

// File: rtl/canvas_clear_sweep.sv
// Linear address sweep 0..NUM_ADDR-1, one step per enabled cycle, with a done pulse on the last one.
module canvas_clear_sweep
  import canvas_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_ADDR = CANVAS_PIXELS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_done
);

  logic [ADDR_W-1:0] r_addr;
  logic              w_last;

  assign w_last = (r_addr == ADDR_W'(NUM_ADDR - 1));

  // Wraps to 0 after the last address so the next sweep starts clean.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_done = i_en && w_last;

endmodule

// File: rtl/canvas_port_arbiter.sv
// Shares the single canvas RAM port between pen, recognizer readout and clear sweep.
// Define CANVAS_AUTO_CLEAR_EN to erase the canvas after every recognized character.
module canvas_port_arbiter
  import canvas_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned CHAR_W      = DEF_CHAR_W,
  parameter int unsigned TIMEOUT_CYC = 2047
) (
  input logic                   i_clk,
  input logic                   i_rst,
  canvas_port_arbiter_if.master io_bus
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_e        r_state;
  logic              r_busy;
  logic              r_rec_end_write;
  logic              r_char_valid;
  logic [CHAR_W-1:0] r_char_data;
  logic              r_timeout_err;
  logic              r_char_overrun;
  logic [WDOG_W-1:0] r_wdog;

  logic              w_sweep_en;
  logic              w_sweep_done;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_capture;
  logic              w_char_take;

  assign w_sweep_en  = (r_state == StClear);
  assign w_capture   = (r_state == StRecog) && io_bus.rec_ready_to_write;
  assign w_char_take = r_char_valid && io_bus.char_ready;

  canvas_clear_sweep #(
    .ADDR_W  (ADDR_W),
    .NUM_ADDR(CANVAS_PIXELS)
  ) u_sweep (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_sweep_en),
    .o_addr(w_sweep_addr),
    .o_done(w_sweep_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= StIdle;
      r_busy          <= 1'b0;
      r_rec_end_write <= 1'b0;
      r_char_valid    <= 1'b0;
      r_char_data     <= '0;
      r_timeout_err   <= 1'b0;
      r_char_overrun  <= 1'b0;
      r_wdog          <= '0;
    end else begin
      r_rec_end_write <= 1'b0;
      if (w_char_take) begin
        r_char_valid <= 1'b0;
      end
      // A capture in the same cycle as a handshake keeps the new character pending.
      if (w_capture) begin
        r_char_data  <= io_bus.rec_write_data;
        r_char_valid <= 1'b1;
        if (r_char_valid && !io_bus.char_ready) begin
          r_char_overrun <= 1'b1;
        end
      end
      unique case (r_state)
        StIdle: begin
          if (io_bus.clear_req) begin
            r_state <= StClear;
            r_busy  <= 1'b1;
          end else if (io_bus.draw_done) begin
            r_state         <= StRecog;
            r_busy          <= 1'b1;
            r_rec_end_write <= 1'b1;
            r_wdog          <= '0;
          end
        end
        StRecog: begin
          if (w_capture) begin
`ifdef CANVAS_AUTO_CLEAR_EN
            r_state <= StClear;
            r_busy  <= 1'b1;
`else
            r_state <= StIdle;
            r_busy  <= 1'b0;
`endif
          end else if (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= StIdle;
            r_busy        <= 1'b0;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        StClear: begin
          if (w_sweep_done) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    io_bus.mem_addr      = io_bus.draw_addr;
    io_bus.mem_we        = io_bus.draw_we;
    io_bus.mem_wdata     = io_bus.draw_data;
    io_bus.draw_stall    = 1'b0;
    io_bus.rec_read_data = 1'b0;
    unique case (r_state)
      StRecog: begin
        io_bus.mem_addr      = io_bus.rec_read_addr;
        io_bus.mem_we        = 1'b0;
        io_bus.mem_wdata     = 1'b0;
        io_bus.draw_stall    = 1'b1;
        io_bus.rec_read_data = (io_bus.rec_read_enable || r_rec_end_write) && io_bus.mem_rdata;
      end
      StClear: begin
        io_bus.mem_addr   = w_sweep_addr;
        io_bus.mem_we     = 1'b1;
        io_bus.mem_wdata  = 1'b0;
        io_bus.draw_stall = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign io_bus.rec_end_write = r_rec_end_write;
  assign io_bus.char_valid    = r_char_valid;
  assign io_bus.char_data     = r_char_data;
  assign io_bus.busy          = r_busy;
  assign io_bus.timeout_err   = r_timeout_err;
  assign io_bus.char_overrun  = r_char_overrun;

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Self-checking bench for canvas_port_arbiter: RAM, recognizer and canvas-content model.
module tb_canvas_port_arbiter;
  import canvas_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 8;
  localparam int          NV = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  canvas_port_arbiter_if #(.ADDR_W(AW), .CHAR_W(CW)) bus ();

  canvas_port_arbiter #(
    .ADDR_W     (AW),
    .CHAR_W     (CW),
    .TIMEOUT_CYC(2047)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  // Canvas RAM with combinational read, and the expected canvas contents.
  bit ram      [CANVAS_PIXELS];
  bit model_px [CANVAS_PIXELS];
  always @(posedge clk) if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr];

  // Recognizer: sweeps all pixels after rec_end_write, answers 1025 cycles later.
  int          rec_cnt = 0;
  int          rec_sum = 0;
  bit          rec_mute = 1'b0;
  logic [CW-1:0] rec_char = '0;
  logic        rec_rd_en = 1'b0;
  logic        force_rre = 1'b0;
  assign bus.rec_read_enable = rec_rd_en | force_rre;

  initial begin
    bus.rec_read_addr      = '0;
    bus.rec_ready_to_write = 1'b0;
    bus.rec_write_data     = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.rec_ready_to_write = 1'b0;
      rec_rd_en              = 1'b0;
      if (rec_cnt == 0) begin
        if (bus.rec_end_write === 1'b1) begin
          rec_cnt = 1;
          rec_sum = 0;
        end
      end else if (rec_cnt <= CANVAS_PIXELS) begin
        rec_rd_en         = 1'b1;
        bus.rec_read_addr = AW'(rec_cnt - 1);
        @(negedge clk);
        rec_sum += (bus.rec_read_data === 1'b1) ? 1 : 0;
        rec_cnt++;
      end else begin
        bus.rec_ready_to_write = !rec_mute;
        bus.rec_write_data     = rec_char;
        rec_cnt                = 0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < CANVAS_PIXELS; i++) c += model_px[i] ? 1 : 0;
    return c;
  endfunction

  function automatic int ram_diffs();
    int d = 0;
    for (int i = 0; i < CANVAS_PIXELS; i++) if (ram[i] != model_px[i]) d++;
    return d;
  endfunction

  task automatic idle_inputs();
    bus.draw_we   = 1'b0;
    bus.draw_addr = '0;
    bus.draw_data = 1'b0;
    bus.draw_done = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem"}, 32'({bus.mem_we, bus.mem_wdata, bus.mem_addr}), 32'd0);
    chk({tag, "_flags"}, 32'({bus.draw_stall, bus.rec_end_write, bus.rec_read_data, bus.char_valid,
                              bus.busy, bus.timeout_err, bus.char_overrun}), 32'd0);
    chk({tag, "_char_data"}, 32'(bus.char_data), 32'd0);
  endtask

  // Called in the first CLEAR cycle; pen keeps requesting at 300 to prove it is stalled.
  task automatic expect_clear(input string tag);
    int k   = 0;
    int bad = 0;
    bus.draw_we   = 1'b1;
    bus.draw_addr = AW'(300);
    bus.draw_data = 1'b1;
    #1;
    while (bus.busy === 1'b1 && k < 1100) begin
      if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 1'b0 || bus.mem_addr !== AW'(k) ||
          bus.draw_stall !== 1'b1) bad++;
      tick();
      if (k >= 1000) bus.draw_we = 1'b0;
      #1;
      k++;
    end
    chk({tag, "_clear_len"}, 32'(k), 32'd1024);
    chk({tag, "_clear_sweep"}, 32'(bad), 32'd0);
    for (int i = 0; i < CANVAS_PIXELS; i++) model_px[i] = 1'b0;
    idle_inputs();
    tick();
    chk({tag, "_clear_ram"}, 32'(ram_diffs()), 32'd0);
  endtask

  // Pen write at 37 together with draw_done, then a full recognition returning ch.
  task automatic recognize(input logic [CW-1:0] ch, input string tag);
    int n   = 0;
    int bad = 0;
    int exp_pop;
    rec_char      = ch;
    rec_mute      = 1'b0;
    bus.draw_we   = 1'b1;
    bus.draw_addr = AW'(37);
    bus.draw_data = 1'b1;
    bus.draw_done = 1'b1;
    model_px[37]  = 1'b1;
    exp_pop       = popcount();
    #1;
    chk({tag, "_done_cycle_write"},
        32'({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.draw_stall}),
        32'({1'b1, AW'(37), 1'b1, 1'b0}));
    tick();
    bus.draw_done = 1'b0;
    bus.draw_we   = 1'($urandom_range(0, 1));
    bus.draw_addr = AW'($urandom_range(0, CANVAS_PIXELS - 1));
    #1;
    chk({tag, "_end_write"}, 32'(bus.rec_end_write), 32'd1);
    chk({tag, "_stall"}, 32'({bus.draw_stall, bus.busy, bus.mem_we}), 32'b110);
    while (!(bus.char_valid === 1'b1 && bus.char_data === ch) && n < 1100) begin
      tick();
      bus.draw_we   = (n < 1020) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.draw_addr = AW'($urandom_range(0, CANVAS_PIXELS - 1));
      bus.draw_data = 1'($urandom_range(0, 1));
      #1;
      n++;
      if (!(bus.char_valid === 1'b1 && bus.char_data === ch)) begin
        if (bus.mem_we !== 1'b0 || bus.rec_end_write !== 1'b0 || bus.draw_stall !== 1'b1) bad++;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'd1026);
    chk({tag, "_recog_port"}, 32'(bad), 32'd0);
    chk({tag, "_char"}, 32'({bus.char_valid, bus.char_data}), 32'({1'b1, ch}));
    chk({tag, "_readout_pop"}, 32'(rec_sum), 32'(exp_pop));
`ifdef CANVAS_AUTO_CLEAR_EN
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd1);
    expect_clear(tag);
`else
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    idle_inputs();
    tick();
    chk({tag, "_ram"}, 32'(ram_diffs()), 32'd0);
`endif
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic          data;
    logic          rre;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic          exp_wdata;
    logic          exp_stall;
    logic          exp_rrd;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int            n;
    int            bad;
    logic          r_we;
    logic          r_d;
    logic [AW-1:0] r_a;

    vecs[0] = '{1'b1, 10'd37,   1'b1, 1'b0, 1'b1, 10'd37,   1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 10'd37,   1'b0, 1'b1, 1'b0, 10'd37,   1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 10'd1023, 1'b1, 1'b0, 1'b1, 10'd1023, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 10'd0,    1'b1, 1'b1, 1'b1, 10'd0,    1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 10'd37,   1'b0, 1'b0, 1'b1, 10'd37,   1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 10'd640,  1'b1, 1'b0, 1'b1, 10'd640,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 10'd640,  1'b1, 1'b1, 1'b0, 10'd640,  1'b1, 1'b0, 1'b0};

    idle_inputs();
    bus.char_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // IDLE port muxing from the vector table.
    for (int i = 0; i < NV; i++) begin
      bus.draw_we   = vecs[i].we;
      bus.draw_addr = vecs[i].addr;
      bus.draw_data = vecs[i].data;
      force_rre     = vecs[i].rre;
      #1;
      chk($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d_stall", i), 32'(bus.draw_stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_rrd", i), 32'(bus.rec_read_data), 32'(vecs[i].exp_rrd));
      if (vecs[i].we) model_px[vecs[i].addr] = vecs[i].data;
      tick();
    end
    force_rre = 1'b0;

    // Random pen traffic in IDLE.
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_a  = AW'($urandom_range(0, CANVAS_PIXELS - 1));
      r_d  = 1'($urandom_range(0, 1));
      bus.draw_we   = r_we;
      bus.draw_addr = r_a;
      bus.draw_data = r_d;
      #1;
      if (bus.mem_we !== r_we || bus.draw_stall !== 1'b0 ||
          (r_we && (bus.mem_addr !== r_a || bus.mem_wdata !== r_d))) bad++;
      if (r_we) model_px[r_a] = r_d;
      tick();
    end
    chk("rand_pen_pass", 32'(bad), 32'd0);
    idle_inputs();
    chk("rand_pen_ram", 32'(ram_diffs()), 32'd0);

    recognize(8'd65, "recog1");
    chk("recog1_no_overrun", 32'(bus.char_overrun), 32'd0);

    recognize(8'd66, "recog2");
    chk("overrun_flag", 32'(bus.char_overrun), 32'd1);
    bus.char_ready = 1'b1;
    tick();
    bus.char_ready = 1'b0;
    #1;
    chk("handshake_clears", 32'(bus.char_valid), 32'd0);

    // Recognizer never answers.
    rec_mute      = 1'b1;
    bus.draw_done = 1'b1;
    #1;
    tick();
    bus.draw_done = 1'b0;
    #1;
    chk("to_end_write", 32'({bus.rec_end_write, bus.timeout_err}), 32'b10);
    n = 0;
    while (bus.busy === 1'b1 && n < 2100) begin
      tick();
      #1;
      n++;
    end
    chk("to_len", 32'(n), 32'd2047);
    chk("to_err", 32'(bus.timeout_err), 32'd1);
    chk("to_no_char", 32'(bus.char_valid), 32'd0);
    rec_mute = 1'b0;
    tick();

    // clear_req beats draw_done; the simultaneous pen write still lands.
    bus.clear_req = 1'b1;
    bus.draw_done = 1'b1;
    bus.draw_we   = 1'b1;
    bus.draw_addr = AW'(200);
    bus.draw_data = 1'b1;
    #1;
    chk("clr_pen_write", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
        32'({1'b1, AW'(200), 1'b1}));
    tick();
    idle_inputs();
    #1;
    chk("clr_entry", 32'({bus.rec_end_write, bus.busy, bus.draw_stall}), 32'b011);
    expect_clear("clr");
    chk("clr_done_dropped", 32'({bus.busy, bus.rec_end_write}), 32'd0);

    // Reset in the middle of a clear sweep.
    bus.draw_we   = 1'b1;
    bus.draw_data = 1'b1;
    bus.draw_addr = AW'(400);
    model_px[400] = 1'b1;
    tick();
    bus.draw_addr = AW'(700);
    model_px[700] = 1'b1;
    tick();
    idle_inputs();
    bus.clear_req = 1'b1;
    #1;
    tick();
    bus.clear_req = 1'b0;
    #1;
    n = 0;
    while (bus.mem_addr !== AW'(500) && n < 600) begin
      tick();
      #1;
      n++;
    end
    chk("rst_sweep_pos", 32'(n), 32'd500);
    rst = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    for (int i = 0; i <= 500; i++) model_px[i] = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'({bus.busy, bus.mem_we, bus.draw_stall}), 32'd0);
    tick();
    chk("post_rst_ram", 32'(ram_diffs()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/canvas_port_arbiter.md
Name: canvas_port_arbiter

Overview:
- Owns the single port of the 32x32 1-bit canvas RAM and shares it between the pen/draw writer, the character recognizer's readout sweep and an internal clear sweep.
- Sequences each recognition: draw_done, then recognizer readout, then character capture, then optional auto-clear.
- The captured character goes to the text side through a valid/ready handshake.
- Sits between the drawing front-end, the canvas RAM (combinational read) and the recognizer.

Parameters:
- ADDR_W, 10, canvas address width (row = addr[9:5], column = addr[4:0]).
- CHAR_W, 8, recognized character width.
- TIMEOUT_CYC, 2047, maximum cycles in RECOG before abort.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- draw_we  in  1  pen write request
- draw_addr  in  ADDR_W  pen write address
- draw_data  in  1  pen pixel value
- draw_done  in  1  pulse: user finished the glyph
- clear_req  in  1  pulse: erase the canvas
- draw_stall  out  1  pen writes are not accepted this cycle
- rec_end_write  out  1  one-cycle start pulse to the recognizer
- rec_read_enable  in  1  recognizer read strobe
- rec_read_addr  in  ADDR_W  recognizer read address
- rec_read_data  out  1  pixel returned to the recognizer, same cycle
- rec_ready_to_write  in  1  recognizer result valid (pulse)
- rec_write_data  in  CHAR_W  recognizer result
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  1  RAM write data
- mem_rdata  in  1  RAM combinational read data
- char_valid  out  1  captured character pending
- char_data  out  CHAR_W  captured character
- char_ready  in  1  consumer accepts the character
- busy  out  1  state is not IDLE
- timeout_err  out  1  sticky: RECOG aborted
- char_overrun  out  1  sticky: new character arrived while char_valid was still set

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-sweep):
  - state IDLE; sweep counter 0; watchdog 0.
  - All outputs 0, including char_data, timeout_err and char_overrun.
  - An interrupted clear sweep is abandoned, not resumed.
- States are IDLE, RECOG, CLEAR.
- IDLE:
  - mem_addr = draw_addr, mem_we = draw_we, mem_wdata = draw_data, draw_stall = 0.
  - clear_req goes to CLEAR. It has priority over a simultaneous draw_done, which is dropped.
  - Otherwise draw_done goes to RECOG.
  - A draw_we in the same cycle as draw_done or clear_req is still written.
- RECOG:
  - rec_end_write = 1 in the first RECOG cycle only; it is registered from the transition.
  - mem_addr = rec_read_addr, mem_we = 0.
  - rec_read_data = mem_rdata combinationally, whenever rec_read_enable or rec_end_write is high. It is 0 otherwise.
  - draw_stall = 1; pen writes are dropped and the drawer must hold its request.
  - Expected result: rec_ready_to_write arrives 1025 cycles after the rec_end_write cycle.
  - On rec_ready_to_write: char_data <= rec_write_data and char_valid <= 1.
    - If char_valid was already 1 and char_ready is low: char_overrun <= 1 and the new character overwrites the old one.
  - After capture, the next state is CLEAR if auto-clear is enabled, else IDLE.
  - The watchdog counts RECOG cycles. When it reaches TIMEOUT_CYC with no result: timeout_err <= 1, state IDLE, no character is captured.
  - clear_req and draw_done are ignored in RECOG.
- CLEAR:
  - mem_we = 1, mem_wdata = 0, mem_addr = sweep counter, running 0..1023, one address per cycle.
  - Exit to IDLE after writing address 1023; the sweep counter wraps to 0. CLEAR lasts exactly 1024 cycles.
  - draw_stall = 1; clear_req, draw_done and rec_* inputs are ignored.
- Character handshake:
  - char_valid stays high until the cycle char_valid && char_ready; it clears on the next edge.
  - The handshake is independent of state.
- busy is registered and equals (state != IDLE).

Optional Feature:
- Macro: CANVAS_AUTO_CLEAR_EN.
- Defined: a successful RECOG goes directly to CLEAR, so the canvas is erased after every recognized character.
- Undefined: RECOG returns to IDLE and the canvas is erased only by clear_req.
- Timeout always returns to IDLE, with or without the macro.

Decomposition:
- Shared package canvas_pkg holds:
  - the state enum (IDLE, RECOG, CLEAR);
  - CANVAS_W = 32, CANVAS_H = 32, CANVAS_PIXELS = 1024;
  - the default ADDR_W and CHAR_W.
- One natural sub-module, canvas_clear_sweep: the address counter plus done pulse, reusable by the display side.

Test Plan:
- Pen write addr 37, data 1 in IDLE, then draw_done: mem_we = 1 at addr 37 in that cycle; next cycle rec_end_write = 1 and draw_stall = 1.
- Recognizer model sweeps 0..1023 and returns 8'd65 after 1025 cycles: char_valid = 1, char_data = 65, busy drops (macro off) or 1024 zero-writes follow (macro on).
- Hold char_ready = 0, then complete a second recognition: char_overrun = 1, char_data updated; char_ready = 1 clears char_valid next cycle.
- Recognizer never responds: timeout_err = 1 after 2047 RECOG cycles, state IDLE, char_valid stays 0.
- clear_req and draw_done in the same IDLE cycle: CLEAR is entered, no rec_end_write; pen writes during CLEAR are stalled and not written.
- rst asserted at sweep address 500: all outputs 0 next cycle, state IDLE, no further mem_we.
